pc_stall_controller: RTL

Sequences the PC enable and the IF/ID and ID/EX pipeline-register controls of the semiMIPS pipeline. It sits between the main control unit, the hazard detector and the PC. It forces PC counting during pipeline fill after reset, then arbitrates stall and flush requests: taken branch, load-use and multicycle mult/div. It replaces the fill-time combinational PC-enable bypass with a deterministic, reset-driven sequencer.

---
 rtl/pc_stall_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_stall_controller.sv
// PC enable and IF/ID, ID/EX pipeline-register sequencer for the semiMIPS pipeline.
// Handles pipeline fill after reset, then arbitrates branch flush, load-use bubble and multicycle stalls.
module pc_stall_controller #(
  parameter int unsigned FILL_CYCLES = 1,
  parameter int unsigned MC_LAT      = 4,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcen_req,
  input  logic              ctrl_valid,
  input  logic              branch_taken,
  input  logic              load_use,
  input  logic              mc_start,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [2:0]        state,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [2:0] ST_FILL     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_STALL_MC = 3'd2;

  localparam logic [3:0] FILL_INIT = 4'(FILL_CYCLES - 1);
  localparam logic [3:0] MC_INIT   = 4'(MC_LAT - 2);

  logic [2:0]        state_q, state_d;
  logic [3:0]        fill_cnt_q, fill_cnt_d;
  logic [3:0]        mc_cnt_q, mc_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    mc_cnt_d   = mc_cnt_q;

    case (state_q)
      ST_FILL: begin
        if (fill_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fill_cnt_d = fill_cnt_q - 4'd1;
        end
      end

      ST_RUN: begin
        // Hazards outrank ctrl_valid; only the normal path consults it.
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (mc_start) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          state_d  = ST_STALL_MC;
          mc_cnt_d = MC_INIT;
        end else begin
          pc_en   = ctrl_valid ? pcen_req : 1'b1;
          ifid_en = pc_en;
        end
      end

      ST_STALL_MC: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (mc_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          mc_cnt_d = mc_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= FILL_INIT;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
